// File: rtl/ula_pkg.sv
// Shared constants and result type for the 8-bit 74181-style ALU.
package ula_pkg;

  localparam int unsigned Width      = 8;
  localparam int unsigned SliceWidth = 4;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  localparam logic [3:0] S_PASS_A = 4'b0000;
  localparam logic [3:0] S_ZERO   = 4'b0011;
  localparam logic [3:0] S_SUB    = 4'b0110;
  localparam logic [3:0] S_XOR    = 4'b0110;
  localparam logic [3:0] S_ADD    = 4'b1001;
  localparam logic [3:0] S_AND    = 4'b1011;
  localparam logic [3:0] S_ONES   = 4'b1100;
  localparam logic [3:0] S_DEC    = 4'b1111;

  typedef struct packed {
    logic [Width-1:0] f;
    logic             c_out;
    logic             a_eq_b;
  } ula_result_t;

endpackage

// File: rtl/ula_8bits_if.sv
// Operand/function/result bundle of the ALU; master drives operands, slave returns results.
interface ula_8bits_if;
  import ula_pkg::*;

  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             c_in;
  logic [Width-1:0] f;
  logic             c_out;
  logic             a_eq_b;

  modport master (
    output a, b, s, m, c_in,
    input  f, c_out, a_eq_b
  );

  modport slave (
    input  a, b, s, m, c_in,
    output f, c_out, a_eq_b
  );

endinterface

// File: rtl/ula_4bits.sv
// Combinational 4-bit 74181-style slice: 16 logic and 16 arithmetic functions.
module ula_4bits
  import ula_pkg::*;
(
  input  logic [SliceWidth-1:0] a,
  input  logic [SliceWidth-1:0] b,
  input  logic [3:0]            s,
  input  logic                  m,
  input  logic                  c_in,
  output logic [SliceWidth-1:0] f,
  output logic                  c_out
);

  logic [SliceWidth-1:0] p;
  logic [SliceWidth-1:0] q;
  logic [SliceWidth:0]   sum;
  logic [SliceWidth-1:0] logic_f;

  always_comb begin
    p   = a | (b & {SliceWidth{s[0]}}) | (~b & {SliceWidth{s[1]}});
    q   = (a & b & {SliceWidth{s[3]}}) | (a & ~b & {SliceWidth{s[2]}});
    sum = {1'b0, p} + {1'b0, q} + {{SliceWidth{1'b0}}, c_in};
  end

  always_comb begin
    logic_f = '0;
    unique case (s)
      4'd0:    logic_f = ~a;
      4'd1:    logic_f = ~(a | b);
      4'd2:    logic_f = ~a & b;
      4'd3:    logic_f = '0;
      4'd4:    logic_f = ~(a & b);
      4'd5:    logic_f = ~b;
      4'd6:    logic_f = a ^ b;
      4'd7:    logic_f = a & ~b;
      4'd8:    logic_f = ~a | b;
      4'd9:    logic_f = ~(a ^ b);
      4'd10:   logic_f = b;
      4'd11:   logic_f = a & b;
      4'd12:   logic_f = '1;
      4'd13:   logic_f = a | ~b;
      4'd14:   logic_f = a | b;
      default: logic_f = a;
    endcase
  end

  // Carry is forced low in logic mode so it cannot leak into the next slice.
  always_comb begin
    if (m == MODE_LOGIC) begin
      f     = logic_f;
      c_out = 1'b0;
    end else begin
      f     = sum[SliceWidth-1:0];
      c_out = sum[SliceWidth];
    end
  end

endmodule

// File: rtl/ula_8bits.sv
// 8-bit registered ALU built from two rippled 4-bit slices; one-cycle latency.
module ula_8bits
  import ula_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ula_8bits_if.slave  bus
);

  logic [Width-1:0] f_next;
  logic             c_mid;
  logic             c_next;
  ula_result_t      res_d;
  ula_result_t      res_q;

  ula_4bits u_lo (
    .a     (bus.a[3:0]),
    .b     (bus.b[3:0]),
    .s     (bus.s),
    .m     (bus.m),
    .c_in  (bus.c_in),
    .f     (f_next[3:0]),
    .c_out (c_mid)
  );

  ula_4bits u_hi (
    .a     (bus.a[7:4]),
    .b     (bus.b[7:4]),
    .s     (bus.s),
    .m     (bus.m),
    .c_in  (c_mid),
    .f     (f_next[7:4]),
    .c_out (c_next)
  );

  always_comb begin
    res_d        = '0;
    res_d.f      = f_next;
    res_d.c_out  = c_next;
    res_d.a_eq_b = &f_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      res_q <= res_d;
    end
  end

  assign bus.f      = res_q.f;
  assign bus.c_out  = res_q.c_out;
  assign bus.a_eq_b = res_q.a_eq_b;

endmodule

// File: tb/tb_ula_8bits.sv
// Directed and swept checks of ula_8bits against hand values and a table-based model.
module tb_ula_8bits;
  import ula_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  ula_8bits_if bus ();

  ula_8bits dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model built from the function tables: f = x + y + c_in as a 9-bit sum.
  function automatic ula_result_t ref_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] s, input logic m,
                                            input logic cin);
    ula_result_t r;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [8:0]  sum;
    r = '0;
    if (m) begin
      case (s)
        4'd0:    r.f = ~a;
        4'd1:    r.f = ~(a | b);
        4'd2:    r.f = ~a & b;
        4'd3:    r.f = 8'h00;
        4'd4:    r.f = ~(a & b);
        4'd5:    r.f = ~b;
        4'd6:    r.f = a ^ b;
        4'd7:    r.f = a & ~b;
        4'd8:    r.f = ~a | b;
        4'd9:    r.f = ~(a ^ b);
        4'd10:   r.f = b;
        4'd11:   r.f = a & b;
        4'd12:   r.f = 8'hFF;
        4'd13:   r.f = a | ~b;
        4'd14:   r.f = a | b;
        default: r.f = a;
      endcase
      r.c_out = 1'b0;
    end else begin
      case (s)
        4'd0:    begin x = a;      y = 8'h00;  end
        4'd1:    begin x = a | b;  y = 8'h00;  end
        4'd2:    begin x = a | ~b; y = 8'h00;  end
        4'd3:    begin x = 8'hFF;  y = 8'h00;  end
        4'd4:    begin x = a;      y = a & ~b; end
        4'd5:    begin x = a | b;  y = a & ~b; end
        4'd6:    begin x = a;      y = ~b;     end
        4'd7:    begin x = 8'hFF;  y = a & ~b; end
        4'd8:    begin x = a;      y = a & b;  end
        4'd9:    begin x = a;      y = b;      end
        4'd10:   begin x = a | ~b; y = a & b;  end
        4'd11:   begin x = 8'hFF;  y = a & b;  end
        4'd12:   begin x = a;      y = a;      end
        4'd13:   begin x = a | b;  y = a;      end
        4'd14:   begin x = a | ~b; y = a;      end
        default: begin x = 8'hFF;  y = a;      end
      endcase
      sum     = {1'b0, x} + {1'b0, y} + {8'h00, cin};
      r.f     = sum[7:0];
      r.c_out = sum[8];
    end
    r.a_eq_b = &r.f;
    return r;
  endfunction

  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                       input logic m, input logic cin);
    bus.a    = a;
    bus.b    = b;
    bus.s    = s;
    bus.m    = m;
    bus.c_in = cin;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] ef, input logic ec, input logic eq);
    total++;
    assert ({bus.f, bus.c_out, bus.a_eq_b} === {ef, ec, eq})
    else begin
      bad++;
      $error("FAIL %s: got f=%0d c_out=%b a_eq_b=%b, want f=%0d c_out=%b a_eq_b=%b",
             tag, bus.f, bus.c_out, bus.a_eq_b, ef, ec, eq);
    end
  endtask

  initial begin
    logic [7:0]  a_set [6];
    logic [7:0]  b_set [4];
    ula_result_t exp_r;
    a_set = '{8'd0, 8'd51, 8'd102, 8'd153, 8'd204, 8'd255};
    b_set = '{8'd0, 8'd85, 8'd170, 8'd255};

    // Reset with live operands that would otherwise give a nonzero result.
    rst = 1'b1;
    apply(8'hA5, 8'h3C, S_ADD, MODE_ARITH, 1'b1);
    apply(8'hFF, 8'h00, S_ONES, MODE_LOGIC, 1'b0);
    check("reset", 8'h00, 1'b0, 1'b0);

    rst = 1'b0;
    apply(8'd51, 8'd85, S_ADD, MODE_ARITH, 1'b0);
    check("add", 8'd136, 1'b0, 1'b0);

    // Operand changes between edges must not reach the outputs.
    bus.a = 8'd0;
    bus.s = S_ONES;
    bus.m = MODE_LOGIC;
    #3;
    check("hold", 8'd136, 1'b0, 1'b0);

    apply(8'd51, 8'd85, S_ADD, MODE_ARITH, 1'b1);
    check("add_cin", 8'd137, 1'b0, 1'b0);
    apply(8'd204, 8'd85, S_ADD, MODE_ARITH, 1'b1);
    check("add_carry", 8'd34, 1'b1, 1'b0);

    apply(8'd102, 8'd102, S_SUB, MODE_ARITH, 1'b0);
    check("cmp_eq", 8'd255, 1'b0, 1'b1);
    apply(8'd102, 8'd102, S_SUB, MODE_ARITH, 1'b1);
    check("cmp_cin", 8'd0, 1'b1, 1'b0);

    apply(8'd0, 8'd0, S_DEC, MODE_ARITH, 1'b0);
    check("dec_wrap", 8'd255, 1'b0, 1'b1);
    apply(8'd255, 8'd0, S_PASS_A, MODE_ARITH, 1'b1);
    check("inc_wrap", 8'd0, 1'b1, 1'b0);

    apply(8'd240, 8'd85, S_XOR, MODE_LOGIC, 1'b1);
    check("log_xor", 8'd165, 1'b0, 1'b0);
    apply(8'd240, 8'd85, S_AND, MODE_LOGIC, 1'b1);
    check("log_and", 8'd80, 1'b0, 1'b0);
    apply(8'd240, 8'd85, S_ZERO, MODE_LOGIC, 1'b1);
    check("log_zero", 8'd0, 1'b0, 1'b0);
    apply(8'd240, 8'd85, S_ONES, MODE_LOGIC, 1'b1);
    check("log_ones", 8'd255, 1'b0, 1'b1);

    // Reset wins over an operation presented in the same cycle.
    rst = 1'b1;
    apply(8'd204, 8'd85, S_ADD, MODE_ARITH, 1'b1);
    check("reset_override", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    apply(8'd204, 8'd85, S_ADD, MODE_ARITH, 1'b1);
    check("after_reset", 8'd34, 1'b1, 1'b0);

    for (int mi = 0; mi < 2; mi++) begin
      for (int si = 0; si < 16; si++) begin
        for (int ai = 0; ai < 6; ai++) begin
          for (int bi = 0; bi < 4; bi++) begin
            for (int ci = 0; ci < 2; ci++) begin
              exp_r = ref_model(a_set[ai], b_set[bi], 4'(si), 1'(mi), 1'(ci));
              apply(a_set[ai], b_set[bi], 4'(si), 1'(mi), 1'(ci));
              check($sformatf("sweep m=%0d s=%0d a=%0d b=%0d c=%0d", mi, si, a_set[ai],
                              b_set[bi], ci), exp_r.f, exp_r.c_out, exp_r.a_eq_b);
            end
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
